bar_collision_scorer: RTL and testbench
=======================================

BAR_COLLISION_SCORER -- requirements
Module: bar_collision_scorer

Interface
REQ-001 Parameter NUM_BARS, default 2, number of bar generators observed.
REQ-002 Parameter BIRD_X, default 200, fixed bird left edge in pixels.
REQ-003 Parameter BIRD_SIZE, default 16, bird square side in pixels.
REQ-004 Parameter BAR_WIDTH, default 40, bar width in pixels.
REQ-005 Parameter GAP_HALF, default 60, half-height of the bar gap in pixels.
REQ-006 Parameter SCORE_MAX, default 999, score saturation value.
REQ-007 clk_25MHz  input  1  single system clock; all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 game_start  input  1  level; high enables play.
REQ-010 x_bar  input  NUM_BARS x 10  left edge of each bar.
REQ-011 y_gap  input  NUM_BARS x 9  gap centre of each bar.
REQ-012 wraps  input  NUM_BARS x 1  per-bar pulse/level; high means the bar re-entered at the right.
REQ-013 bird_y  input  10  bird top edge; 0 is the screen top.
REQ-014 lose  output  1  registered; high once the game is over.
REQ-015 score  output  10  registered count of bars passed.
REQ-016 high_score  output  10  registered best score since reset.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 FSM states: IDLE, PLAY, OVER.
REQ-019 Transitions: IDLE->PLAY when game_start=1; PLAY->OVER on hit; OVER is terminal until reset; a game_start drop in PLAY holds PLAY with no updates.
REQ-020 All arithmetic uses 11-bit zero-extended operands, so no wrap occurs on x_bar+BAR_WIDTH, y_gap+GAP_HALF, or bird_y+BIRD_SIZE.
REQ-021 Horizontal overlap for bar i: x_bar[i] < BIRD_X+BIRD_SIZE AND x_bar[i]+BAR_WIDTH > BIRD_X.
REQ-022 Gap clearance for bar i: bird_y+GAP_HALF >= y_gap[i] AND bird_y+BIRD_SIZE <= y_gap[i]+GAP_HALF, with the boundaries counting as clear.
REQ-023 A hit occurs when any bar overlaps without clearance, or when bird_y+BIRD_SIZE >= 480 (ground).
REQ-024 Pass for bar i: x_bar[i]+BAR_WIDTH < BIRD_X AND passed[i]=0.
REQ-025 On a pass in PLAY: set passed[i] and increment score by one per passing bar, saturating at SCORE_MAX.
REQ-026 wraps[i]=1 clears passed[i]; wraps takes priority over a pass on the same cycle, with no increment.
REQ-027 A hit and a pass on the same cycle: the hit wins, score is unchanged, and lose rises.
REQ-028 lose rises on the cycle after the hit is sampled (1-cycle latency) and stays high.
REQ-029 high_score updates to score on entry to OVER when score > high_score.
REQ-030 No evaluation takes place in IDLE or OVER; score and passed[] hold.

Reset
REQ-031 Reset forces state=IDLE, lose=0, score=0, high_score=0, and passed[]=0, asynchronously.
REQ-032 Reset mid-PLAY or mid-OVER has the same effect; high_score is not retained across reset.

Structure
REQ-033 Package flappy_pkg holds the following: SCREEN_W=640, SCREEN_H=480, the state enum typedef, and the default geometry constants.
REQ-034 Sub-module bar_hit_check is combinational and instantiated NUM_BARS times; it outputs overlap, clear, and beyond for one bar.
REQ-035 The FSM, score and high_score counters, and the passed[] flags live in the top module.

Verification
REQ-036 Start with x_bar[0]=300, y_gap=240, bird_y=232 and step x_bar down to 150 -> no lose; score=1 once x_bar[0]+40<200 (x_bar=159).
REQ-037 x_bar[0]=190, y_gap=240, bird_y=150 -> lose=1 one cycle later; state=OVER.
REQ-038 bird_y=464 with no bars overlapping -> lose=1 (ground).
REQ-039 Bar 0 passes with wraps[0] asserted on the same cycle -> score unchanged; re-pass after wrap -> score+1.
REQ-040 Preload score to 999 and pass a bar -> score stays 999; a hit then gives high_score=999.
REQ-041 Assert reset while in OVER with score=5 -> all outputs 0 immediately; IDLE; game_start=1 -> PLAY.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared screen geometry, default bird/bar dimensions and the game state type
// for the bar collision scorer.
package flappy_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DEF_BIRD_X    = 200;
    localparam int DEF_BIRD_SIZE = 16;
    localparam int DEF_BAR_WIDTH = 40;
    localparam int DEF_GAP_HALF  = 60;
    localparam int DEF_SCORE_MAX = 999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/bar_hit_check.sv
// Combinational geometry test of one bar against the bird.
// It reports horizontal overlap, vertical gap clearance, and whether the bar is fully left of the bird.
module bar_hit_check #(
    parameter int BIRD_X    = 200,
    parameter int BIRD_SIZE = 16,
    parameter int BAR_WIDTH = 40,
    parameter int GAP_HALF  = 60
) (
    input  logic [9:0] i_x_bar,
    input  logic [8:0] i_y_gap,
    input  logic [9:0] i_bird_y,
    output logic       o_overlap,
    output logic       o_clear,
    output logic       o_beyond
);

    logic [10:0] w_x;
    logic [10:0] w_x_end;
    logic [10:0] w_gap;
    logic [10:0] w_y;

    // 11-bit operands keep the +offset sums from wrapping.
    assign w_x     = {1'b0, i_x_bar};
    assign w_x_end = w_x + 11'(BAR_WIDTH);
    assign w_gap   = {2'b00, i_y_gap};
    assign w_y     = {1'b0, i_bird_y};

    assign o_overlap = (w_x < 11'(BIRD_X + BIRD_SIZE)) && (w_x_end > 11'(BIRD_X));
    assign o_clear   = ((w_y + 11'(GAP_HALF)) >= w_gap) &&
                       ((w_y + 11'(BIRD_SIZE)) <= (w_gap + 11'(GAP_HALF)));
    assign o_beyond  = w_x_end < 11'(BIRD_X);

endmodule

// File: rtl/bar_collision_scorer.sv
// Game control for a flappy-style game: detects bird/bar and ground collisions,
// counts passed bars with saturation and keeps the best score of the current reset epoch.
module bar_collision_scorer
    import flappy_pkg::*;
#(
    parameter int NUM_BARS  = 2,
    parameter int BIRD_X    = DEF_BIRD_X,
    parameter int BIRD_SIZE = DEF_BIRD_SIZE,
    parameter int BAR_WIDTH = DEF_BAR_WIDTH,
    parameter int GAP_HALF  = DEF_GAP_HALF,
    parameter int SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic                     clk_25MHz,
    input  logic                     reset,
    input  logic                     game_start,
    input  logic [NUM_BARS*10-1:0]   x_bar,
    input  logic [NUM_BARS*9-1:0]    y_gap,
    input  logic [NUM_BARS-1:0]      wraps,
    input  logic [9:0]               bird_y,
    output logic                     lose,
    output logic [9:0]               score,
    output logic [9:0]               high_score,
    output logic [1:0]               state
);

    game_state_t         r_state;
    game_state_t         w_state_nxt;
    logic                r_lose;
    logic [9:0]          r_score;
    logic [9:0]          r_high;
    logic [NUM_BARS-1:0] r_passed;
    logic [NUM_BARS-1:0] w_passed_nxt;
    logic [NUM_BARS-1:0] w_overlap;
    logic [NUM_BARS-1:0] w_clear;
    logic [NUM_BARS-1:0] w_beyond;
    logic [10:0]         w_inc;
    logic                w_ground;
    logic                w_hit;
    logic                w_active;
    logic                w_enter_over;

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [10:0] inc);
        logic [11:0] sum;
        sum = {2'b00, a} + {1'b0, inc};
        if (sum > 12'(SCORE_MAX))
            return 10'(SCORE_MAX);
        return sum[9:0];
    endfunction

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        bar_hit_check #(
            .BIRD_X    (BIRD_X),
            .BIRD_SIZE (BIRD_SIZE),
            .BAR_WIDTH (BAR_WIDTH),
            .GAP_HALF  (GAP_HALF)
        ) u_chk (
            .i_x_bar   (x_bar[g*10 +: 10]),
            .i_y_gap   (y_gap[g*9 +: 9]),
            .i_bird_y  (bird_y),
            .o_overlap (w_overlap[g]),
            .o_clear   (w_clear[g]),
            .o_beyond  (w_beyond[g])
        );
    end

    assign w_ground = (({1'b0, bird_y} + 11'(BIRD_SIZE)) >= 11'(SCREEN_H));
    assign w_active = (r_state == ST_PLAY) && game_start;

    always_comb begin
        w_hit = w_ground;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (w_overlap[i] && !w_clear[i])
                w_hit = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_over = 1'b0;
        case (r_state)
            ST_IDLE: if (game_start) w_state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (game_start && w_hit) begin
                    w_state_nxt  = ST_OVER;
                    w_enter_over = 1'b1;
                end
            end
            ST_OVER: w_state_nxt = ST_OVER;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A hit freezes scoring for that cycle; a wrap beats a pass on the same bar.
    always_comb begin
        w_passed_nxt = r_passed;
        w_inc        = '0;
        if (w_active && !w_hit) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                if (wraps[i]) begin
                    w_passed_nxt[i] = 1'b0;
                end else if (w_beyond[i] && !r_passed[i]) begin
                    w_passed_nxt[i] = 1'b1;
                    w_inc           = w_inc + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            r_lose   <= 1'b0;
            r_score  <= '0;
            r_high   <= '0;
            r_passed <= '0;
        end else begin
            r_passed <= w_passed_nxt;
            r_score  <= sat_add(r_score, w_inc);
            if (w_enter_over) begin
                r_lose <= 1'b1;
                if (r_score > r_high)
                    r_high <= r_score;
            end
        end
    end

    assign lose       = r_lose;
    assign score      = r_score;
    assign high_score = r_high;
    assign state      = r_state;

endmodule

// File: tb/tb_bar_collision_scorer.sv
// Self-checking bench for bar_collision_scorer: directed game scenarios plus a
// randomized run, all compared against a game-level reference model.
module tb_bar_collision_scorer;

    localparam int NB = 2;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        game_start;
    logic [19:0] x_bar;
    logic [17:0] y_gap;
    logic [1:0]  wraps;
    logic [9:0]  bird_y;
    logic        lose;
    logic [9:0]  score;
    logic [9:0]  high_score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode 0 idle, 1 playing, 2 game over.
    int m_mode;
    int m_score;
    int m_high;
    bit m_lose;
    bit m_passed[NB];

    int xb[NB];
    int yg[NB];
    int wr[NB];
    int by;

    always #20 clk_25MHz = ~clk_25MHz;

    bar_collision_scorer dut (
        .clk_25MHz  (clk_25MHz),
        .reset      (reset),
        .game_start (game_start),
        .x_bar      (x_bar),
        .y_gap      (y_gap),
        .wraps      (wraps),
        .bird_y     (bird_y),
        .lose       (lose),
        .score      (score),
        .high_score (high_score),
        .state      (state)
    );

    task automatic drive();
        for (int i = 0; i < NB; i++) begin
            x_bar[i*10 +: 10] = 10'(xb[i]);
            y_gap[i*9 +: 9]   = 9'(yg[i]);
            wraps[i]          = (wr[i] != 0);
        end
        bird_y = 10'(by);
    endtask

    task automatic park();
        for (int i = 0; i < NB; i++) begin
            xb[i] = 600;
            yg[i] = 240;
            wr[i] = 0;
        end
        by = 232;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_score = 0;
        m_high  = 0;
        m_lose  = 0;
        for (int i = 0; i < NB; i++) m_passed[i] = 0;
    endtask

    // One clock of game rules, evaluated on the values about to be sampled.
    task automatic model_step();
        bit hit;
        int gained;
        gained = 0;
        if (m_mode == 0) begin
            if (game_start) m_mode = 1;
        end else if (m_mode == 1 && game_start) begin
            hit = (by + 16 >= 480);
            for (int i = 0; i < NB; i++) begin
                if (xb[i] < 200 + 16 && xb[i] + 40 > 200 &&
                    !(by + 60 >= yg[i] && by + 16 <= yg[i] + 60))
                    hit = 1;
            end
            if (hit) begin
                m_mode = 2;
                m_lose = 1;
                if (m_score > m_high) m_high = m_score;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (wr[i] != 0) m_passed[i] = 0;
                    else if (xb[i] + 40 < 200 && !m_passed[i]) begin
                        m_passed[i] = 1;
                        gained++;
                    end
                end
                m_score = (m_score + gained > 999) ? 999 : m_score + gained;
            end
        end
    endtask

    task automatic cycle();
        drive();
        model_step();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic release_reset();
        @(posedge clk_25MHz);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        game_start = 1'b0;
        park();
        drive();
        assert_reset();
        #5;
        n_checks++;
        if ({lose, score, high_score, state} !== 23'd0)
            $display("FAIL reset_state: got lose=%0b score=%0d high=%0d state=%0d, expected all 0",
                     lose, score, high_score, state);
        else n_pass++;
        release_reset();
        repeat (3) begin
            cycle();
            n_checks++;
            if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)})
                $display("FAIL idle_hold: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                         lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
            else n_pass++;
        end
    endtask

    task automatic test_pass_sweep();
        assert_reset();
        park();
        release_reset();
        game_start = 1'b1;
        cycle();
        for (int x = 300; x >= 150; x--) begin
            xb[0] = x;
            cycle();
            n_checks++;
            if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)})
                $display("FAIL sweep x=%0d: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                         x, lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
            else n_pass++;
        end
        n_checks++;
        if (score !== 10'd1 || lose !== 1'b0 || state !== 2'd1)
            $display("FAIL sweep_final: got score=%0d lose=%0b state=%0d, expected score=1 lose=0 state=1",
                     score, lose, state);
        else n_pass++;
    endtask

    task automatic test_hit();
        assert_reset();
        park();
        release_reset();
        game_start = 1'b1;
        cycle();
        xb[0] = 190;
        by    = 150;
        drive();
        #5;
        n_checks++;
        if (lose !== 1'b0)
            $display("FAIL hit_latency: got lose=%0b before edge, expected 0", lose);
        else n_pass++;
        cycle();
        n_checks++;
        if (lose !== 1'b1 || state !== 2'd2 || score !== 10'd0)
            $display("FAIL hit: got lose=%0b state=%0d score=%0d, expected lose=1 state=2 score=0",
                     lose, state, score);
        else n_pass++;
        xb[0] = 100;
        by    = 232;
        repeat (3) begin
            cycle();
            n_checks++;
            if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)})
                $display("FAIL over_hold: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                         lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
            else n_pass++;
        end
    endtask

    task automatic test_ground();
        assert_reset();
        park();
        release_reset();
        game_start = 1'b1;
        cycle();
        by = 463;
        cycle();
        n_checks++;
        if (lose !== 1'b0 || state !== 2'd1)
            $display("FAIL ground_463: got lose=%0b state=%0d, expected lose=0 state=1", lose, state);
        else n_pass++;
        by = 464;
        cycle();
        n_checks++;
        if (lose !== 1'b1 || state !== 2'd2)
            $display("FAIL ground_464: got lose=%0b state=%0d, expected lose=1 state=2", lose, state);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        int xs[6];
        int ys[6];
        xs = '{216, 160, 190, 190, 190, 190};
        ys = '{150, 150, 180, 284, 232, 285};
        assert_reset();
        park();
        release_reset();
        game_start = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            xb[0] = xs[k];
            by    = ys[k];
            cycle();
            n_checks++;
            if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)})
                $display("FAIL boundary x=%0d y=%0d: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                         xs[k], ys[k], lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
            else n_pass++;
        end
        n_checks++;
        if (lose !== 1'b1)
            $display("FAIL boundary_final: got lose=%0b, expected 1", lose);
        else n_pass++;
    endtask

    task automatic test_wrap_priority();
        assert_reset();
        park();
        release_reset();
        game_start = 1'b1;
        cycle();
        xb[0] = 100;
        wr[0] = 1;
        cycle();
        n_checks++;
        if (score !== 10'd0)
            $display("FAIL wrap_same_cycle: got score=%0d, expected 0", score);
        else n_pass++;
        wr[0] = 0;
        cycle();
        n_checks++;
        if (score !== 10'd1)
            $display("FAIL repass: got score=%0d, expected 1", score);
        else n_pass++;
        cycle();
        n_checks++;
        if (score !== 10'd1)
            $display("FAIL no_double_count: got score=%0d, expected 1", score);
        else n_pass++;
        wr[0] = 1;
        cycle();
        wr[0] = 0;
        cycle();
        n_checks++;
        if (score !== 10'd2 || score !== 10'(m_score))
            $display("FAIL wrap_then_pass: got score=%0d, expected 2 (model %0d)", score, m_score);
        else n_pass++;
        game_start = 1'b0;
        wr[0] = 1;
        cycle();
        wr[0] = 0;
        cycle();
        n_checks++;
        if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)})
            $display("FAIL start_low_hold: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                     lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        assert_reset();
        park();
        xb[0] = 100;
        xb[1] = 100;
        release_reset();
        game_start = 1'b1;
        cycle();
        for (int k = 0; k < 501; k++) begin
            wr[0] = 1; wr[1] = 1;
            cycle();
            wr[0] = 0; wr[1] = 0;
            cycle();
            n_checks++;
            if (score !== 10'(m_score)) begin
                if (bad < 5)
                    $display("FAIL sat_ramp k=%0d: got score=%0d, expected %0d", k, score, m_score);
                bad++;
            end else n_pass++;
        end
        n_checks++;
        if (score !== 10'd999)
            $display("FAIL sat_hold: got score=%0d, expected 999", score);
        else n_pass++;
        xb[0] = 190;
        by    = 150;
        cycle();
        n_checks++;
        if (high_score !== 10'd999 || lose !== 1'b1 || state !== 2'd2)
            $display("FAIL sat_high: got high=%0d lose=%0b state=%0d, expected high=999 lose=1 state=2",
                     high_score, lose, state);
        else n_pass++;
    endtask

    task automatic test_reset_in_over();
        assert_reset();
        park();
        xb[0] = 100;
        release_reset();
        game_start = 1'b1;
        cycle();
        repeat (5) begin
            wr[0] = 1;
            cycle();
            wr[0] = 0;
            cycle();
        end
        xb[0] = 190;
        by    = 150;
        cycle();
        n_checks++;
        if (score !== 10'd5 || high_score !== 10'd5 || state !== 2'd2)
            $display("FAIL over_score5: got score=%0d high=%0d state=%0d, expected 5 5 2",
                     score, high_score, state);
        else n_pass++;
        #7;
        assert_reset();
        #1;
        n_checks++;
        if ({lose, score, high_score, state} !== 23'd0)
            $display("FAIL async_reset_over: got lose=%0b score=%0d high=%0d state=%0d, expected all 0",
                     lose, score, high_score, state);
        else n_pass++;
        release_reset();
        park();
        cycle();
        n_checks++;
        if (state !== 2'd1 || score !== 10'd0)
            $display("FAIL restart: got state=%0d score=%0d, expected state=1 score=0", state, score);
        else n_pass++;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        assert_reset();
        park();
        release_reset();
        for (int n = 0; n < 3000; n++) begin
            game_start = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NB; i++) begin
                xb[i] = int'($urandom_range(0, 639));
                yg[i] = int'($urandom_range(60, 420));
                wr[i] = ($urandom_range(0, 7) == 0) ? 1 : 0;
            end
            by = yg[0] - 60 + int'($urandom_range(0, 110));
            if ($urandom_range(0, 99) == 0 || (m_mode == 2 && $urandom_range(0, 3) == 0)) begin
                drive();
                assert_reset();
                #1;
                n_checks++;
                if ({lose, score, high_score, state} !== 23'd0) begin
                    if (bad < 5)
                        $display("FAIL rand_reset n=%0d: got lose=%0b score=%0d high=%0d state=%0d, expected all 0",
                                 n, lose, score, high_score, state);
                    bad++;
                end else n_pass++;
                release_reset();
            end else begin
                cycle();
                n_checks++;
                if ({lose, score, high_score, state} !== {m_lose, 10'(m_score), 10'(m_high), 2'(m_mode)}) begin
                    if (bad < 5)
                        $display("FAIL rand n=%0d: got lose=%0b score=%0d high=%0d state=%0d, expected lose=%0b score=%0d high=%0d state=%0d",
                                 n, lose, score, high_score, state, m_lose, m_score, m_high, m_mode);
                    bad++;
                end else n_pass++;
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        game_start = 1'b0;
        park();
        drive();
        model_reset();
        test_reset();
        test_pass_sweep();
        test_hit();
        test_ground();
        test_boundaries();
        test_wrap_priority();
        test_saturation();
        test_reset_in_over();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
